// File: rtl/register_mover.sv
// Moves a masked set of eight 32-bit registers between a register RAM and a
// store (out) stream or from a load (in) stream, one register at a time.
module register_mover (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic        direction,
  input  logic [7:0]  mask,
  input  logic        descending,
  input  logic        size_long,
  output logic [2:0]  ram_address,
  output logic [3:0]  ram_byte_enable,
  output logic        ram_write_enable,
  output logic [31:0] ram_data_input,
  input  logic [31:0] ram_data_output,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    OUT     = 3'd3,
    WR      = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  rem_mask;
  logic        desc_q;
  logic        long_q;
  logic        empty_q;
  logic [31:0] out_data_q;
  logic [3:0]  count_q;
  logic [2:0]  cur_reg;
  logic [7:0]  cur_bit;
  logic        last_reg;
  logic        accept;
  logic        out_fire;
  logic        in_fire;

  // Handshakes: a word moves on the rising edge where valid and ready are both
  // high; the producer holds valid and data until then, ready may toggle freely.
  assign out_fire = out_valid && out_ready;
  assign in_fire  = in_valid && in_ready;
  assign accept   = (state == IDLE) && !empty_q && start;

  // Current register: lowest remaining bit ascending, highest descending.
  always_comb begin
    cur_reg = 3'd0;
    if (desc_q) begin
      for (int i = 0; i < 8; i++)
        if (rem_mask[i]) cur_reg = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (rem_mask[i]) cur_reg = 3'(i);
    end
    cur_bit  = 8'b1 << cur_reg;
    last_reg = (rem_mask & ~cur_bit) == 8'h00;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // An empty mask spends one latched cycle in IDLE before DONE.
        if (empty_q)
          state_next = DONE;
        else if (start && mask != 8'h00)
          state_next = direction ? WR : RD_ADDR;
      end
      RD_ADDR: state_next = RD_DATA;
      RD_DATA: state_next = OUT;
      OUT: begin
        if (out_fire)
          state_next = last_reg ? DONE : RD_ADDR;
      end
      WR: begin
        if (in_fire && last_reg)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      rem_mask   <= 8'h00;
      desc_q     <= 1'b0;
      long_q     <= 1'b0;
      empty_q    <= 1'b0;
      out_data_q <= 32'h0;
      count_q    <= 4'd0;
    end else begin
      state   <= state_next;
      empty_q <= accept && (mask == 8'h00);
      if (accept) begin
        rem_mask <= mask;
        desc_q   <= descending;
        long_q   <= size_long;
        count_q  <= 4'd0;
      end
      if (state == RD_DATA)
        out_data_q <= long_q ? ram_data_output : {16'h0000, ram_data_output[15:0]};
      if (out_fire || in_fire) begin
        rem_mask <= rem_mask & ~cur_bit;
        count_q  <= count_q + 4'd1;
      end
    end
  end

  always_comb begin
    ram_address      = 3'd0;
    ram_byte_enable  = 4'b1111;
    ram_write_enable = 1'b0;
    ram_data_input   = 32'h0;
    if (state == RD_ADDR || state == RD_DATA)
      ram_address = cur_reg;
    if (state == WR) begin
      ram_address      = cur_reg;
      ram_byte_enable  = long_q ? 4'b1111 : 4'b0011;
      ram_write_enable = in_valid;
      ram_data_input   = in_data;
    end
  end

  assign out_valid = (state == OUT);
  assign in_ready  = (state == WR);
  assign out_data  = out_data_q;
  assign busy      = (state == RD_ADDR) || (state == RD_DATA) || (state == OUT) ||
                     (state == WR) || empty_q;
  assign done      = (state == DONE);
  assign count     = count_q;

endmodule

// File: tb/tb_register_mover.sv
// Randomized bench for register_mover: a RAM model, an expected-transfer
// scoreboard built from the mask/order rules, and timing checks.
module tb_register_mover;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        direction = 1'b0;
  logic [7:0]  mask = 8'h00;
  logic        descending = 1'b0;
  logic        size_long = 1'b0;
  logic [2:0]  ram_address;
  logic [3:0]  ram_byte_enable;
  logic        ram_write_enable;
  logic [31:0] ram_data_input;
  logic [31:0] ram_data_output;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = 32'h0;
  logic        busy;
  logic        done;
  logic [3:0]  count;

  logic [31:0] mem [8];
  logic [31:0] exp_q[$];
  logic [38:0] exp_wr_q[$];
  logic [31:0] load_words[$];
  int checks = 0;
  int errors = 0;
  int wr_commits = 0;

  logic [79:0] outs;
  localparam logic [79:0] RST_VEC = {3'd0, 4'hF, 73'd0};
  assign outs = {ram_address, ram_byte_enable, ram_write_enable, ram_data_input,
                 out_valid, out_data, in_ready, busy, done, count};

  register_mover dut (
    .clock(clock), .reset_n(reset_n), .start(start), .direction(direction),
    .mask(mask), .descending(descending), .size_long(size_long),
    .ram_address(ram_address), .ram_byte_enable(ram_byte_enable),
    .ram_write_enable(ram_write_enable), .ram_data_input(ram_data_input),
    .ram_data_output(ram_data_output), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .busy(busy), .done(done), .count(count)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  // register RAM: synchronous read, byte-enabled write
  always @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= $urandom;
    end else if (ram_write_enable) begin
      for (int b = 0; b < 4; b++)
        if (ram_byte_enable[b]) mem[ram_address][8*b +: 8] <= ram_data_input[8*b +: 8];
      wr_commits++;
    end
    ram_data_output <= mem[ram_address];
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One operation: builds expectations, drives start and flow control, monitors.
  task automatic run_op(input bit dir, input logic [7:0] m, input bit desc, input bit lng,
                        input bit full_flow, input int stall_first, input bit poke,
                        input int rst_after);
    int order[$];
    logic [31:0] words[$];
    int idx, first_valid, done_cyc, stall, wr_base;
    bit was_stalled, got_reset;
    logic [31:0] held;
    idx = 0; first_valid = -1; done_cyc = -1; stall = stall_first;
    was_stalled = 0; got_reset = 0; held = 32'h0;
    for (int k = 0; k < 8; k++) begin
      int r;
      r = desc ? 7 - k : k;
      if (m[r]) order.push_back(r);
    end
    foreach (order[j]) begin
      if (dir) begin
        logic [31:0] w;
        w = (load_words.size() > 0) ? load_words.pop_front() : $urandom;
        words.push_back(w);
        exp_wr_q.push_back({3'(order[j]), lng ? 4'hF : 4'h3, w});
      end else begin
        exp_q.push_back(lng ? mem[order[j]] : {16'h0000, mem[order[j]][15:0]});
      end
    end
    wr_base = wr_commits;
    direction = dir; mask = m; descending = desc; size_long = lng; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    direction = 1'($urandom); mask = 8'($urandom);
    descending = 1'($urandom); size_long = 1'($urandom);
    for (int cyc = 1; cyc <= 300 && done_cyc < 0 && !got_reset; cyc++) begin
      if (dir && idx < words.size()) begin
        in_valid = full_flow || ($urandom_range(0, 3) != 0);
        in_data  = words[idx];
      end else begin
        in_valid = 1'($urandom);
        in_data  = $urandom;
      end
      out_ready = (stall > 0) ? 1'b0 : (full_flow || ($urandom_range(0, 3) != 0));
      start = poke && (cyc == 2);
      @(negedge clock);
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (was_stalled) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
      end
      was_stalled = out_valid && !out_ready;
      held = out_data;
      if (out_valid && !out_ready && stall > 0) stall--;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("out_extra", 1, 0);
        else check("out_data", out_data, exp_q.pop_front());
      end
      check("we_rule", ram_write_enable, in_valid && in_ready);
      check("busy", busy, !done);
      if (ram_write_enable) begin
        if (exp_wr_q.size() == 0) check("wr_extra", 1, 0);
        else check("wr", {ram_address, ram_byte_enable, ram_data_input}, exp_wr_q.pop_front());
      end
      if (in_valid && in_ready) idx++;
      if (done) done_cyc = cyc;
      @(posedge clock);
      if (rst_after > 0 && idx == rst_after) begin
        #2 reset_n = 1'b0;
        #1 check("reset_outs_async", outs, RST_VEC);
        got_reset = 1;
      end else begin
        #1;
      end
    end
    start = 1'b0;
    if (got_reset) begin
      in_valid = 1'b1;
      repeat (2) @(posedge clock);
      #1;
      check("writes_before_reset", wr_commits - wr_base, rst_after);
      check("reset_outs_held", outs, RST_VEC);
      exp_wr_q.delete();
      in_valid = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
    end else begin
      check("done_seen", done_cyc > 0, 1);
      check("count", count, order.size());
      check("exp_empty", exp_q.size() + exp_wr_q.size(), 0);
      if (full_flow && stall_first == 0) begin
        if (m == 8'h00) check("empty_done_lat", done_cyc, 2);
        else if (dir) check("load_done_lat", done_cyc, order.size() + 1);
        else begin
          check("store_first_lat", first_valid, 3);
          check("store_done_lat", done_cyc, 3 * order.size() + 1);
        end
      end
      if (m == 8'h00) check("empty_no_valid", first_valid, -1);
      out_ready = 1'b0;
      in_valid = 1'b0;
      @(negedge clock);
      check("done_pulse", {done, busy}, 2'b00);
      check("count_hold", count, order.size());
      @(posedge clock); #1;
    end
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1 check("reset_outs", outs, RST_VEC);
    @(negedge clock);
    reset_n = 1'b1;

    // seed r0/r2 through a load, then the store readback
    load_words = {32'h1111_0000, 32'h2222_2222};
    run_op(1, 8'b0000_0101, 0, 1, 1, 0, 0, 0);
    check("r0_value", mem[0], 32'h1111_0000);
    check("r2_value", mem[2], 32'h2222_2222);
    run_op(0, 8'b0000_0101, 0, 1, 1, 0, 0, 0);

    // descending word load
    load_words = {32'hAAAA_BEEF, 32'h5555_1234};
    run_op(1, 8'b1000_0010, 1, 0, 1, 0, 0, 0);

    // empty masks
    run_op(0, 8'h00, 0, 0, 1, 0, 0, 0);
    run_op(1, 8'h00, 1, 1, 1, 0, 0, 0);

    // back-pressure, start while busy, full masks
    run_op(0, 8'b0100_1000, 1, 1, 1, 5, 0, 0);
    run_op(1, 8'h3C, 0, 1, 1, 0, 1, 0);
    run_op(0, 8'h3C, 1, 0, 1, 0, 1, 0);
    run_op(1, 8'hFF, 0, 1, 1, 0, 0, 0);
    run_op(0, 8'hFF, 1, 0, 1, 0, 0, 0);

    // reset in the middle of a load, then a fresh start right after release
    run_op(1, 8'hFF, 0, 1, 1, 0, 0, 3);
    run_op(0, 8'h81, 0, 1, 1, 0, 0, 0);

    repeat (24) begin
      run_op(1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
             1'($urandom), $urandom_range(0, 3), 1'($urandom), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_mover.md
REGISTER_MOVER -- requirements
Module: register_mover

Interface
REQ-001 SHALL have no parameters; data width is fixed at 32, register address at 3 bits, mask at 8 bits.
REQ-002 SHALL have ports, one per line, as follows:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only in IDLE.
- direction  in  1  0 = store (registers -> out stream); 1 = load (in stream -> registers).
- mask  in  8  bit i set = register i transferred.
- descending  in  1  0 = ascending index order; 1 = descending.
- size_long  in  1  1 = 32-bit; 0 = 16-bit (low word).
- ram_address  out  3  register-RAM address.
- ram_byte_enable  out  4  register-RAM byte enables.
- ram_write_enable  out  1  register-RAM write strobe.
- ram_data_input  out  32  register-RAM write data.
- ram_data_output  in  32  register-RAM read data; valid the cycle after the address is presented.
- out_valid  out  1  store-stream data valid.
- out_ready  in  1  store-stream consumer ready.
- out_data  out  32  store-stream data.
- in_valid  in  1  load-stream data valid.
- in_ready  out  1  load-stream ready.
- in_data  in  32  load-stream data.
- busy  out  1  transfer in progress.
- done  out  1  one-cycle completion pulse.
- count  out  4  registers transferred in the current or last operation.

Function
REQ-003 SHALL implement states IDLE, RD_ADDR, RD_DATA, OUT, WR, DONE.
REQ-004 In IDLE with start=1, SHALL latch mask, direction, descending and size_long, clear count, and set busy on the next edge.
REQ-005 After start with latched mask=0, SHALL go to DONE with no RAM access.
REQ-006 Otherwise, SHALL enter RD_ADDR when direction=0 and WR when direction=1.
REQ-007 Current register SHALL be the lowest set bit of the remaining mask (ascending) or the highest (descending).
REQ-008 Current register SHALL be cleared from the remaining mask when its transfer completes.
REQ-009 RD_ADDR SHALL last 1 cycle, driving ram_address = current register and ram_write_enable=0.
REQ-010 RD_DATA SHALL last 1 cycle with ram_address held.
REQ-011 At the end of RD_DATA, SHALL register out_data = ram_data_output when size_long=1, else {16'h0000, ram_data_output[15:0]}.
REQ-012 OUT SHALL assert out_valid with out_data stable until out_valid & out_ready.
REQ-013 On the OUT handshake edge, SHALL increment count, then go to RD_ADDR if mask bits remain, else DONE.
REQ-014 Store latency: start edge to out_valid high SHALL be 3 cycles.
REQ-015 Each further store word SHALL take 3 cycles minimum when out_ready is held high.
REQ-016 WR SHALL assert in_ready and drive ram_address = current register.
REQ-017 In WR, ram_data_input SHALL be in_data.
REQ-018 In WR, ram_byte_enable SHALL be 4'b1111 when size_long=1, else 4'b0011.
REQ-019 In WR, ram_write_enable SHALL equal in_valid; the write and handshake complete on the same edge.
REQ-020 On the WR handshake, SHALL increment count and stay in WR if bits remain, else go to DONE; sustained load throughput SHALL be 1 word per cycle.
REQ-021 Outside WR, ram_write_enable SHALL be 0 and ram_byte_enable SHALL be 4'b1111.
REQ-022 Outside OUT, out_valid SHALL be 0; outside WR, in_ready SHALL be 0.
REQ-023 DONE SHALL last 1 cycle with done=1 and busy=0, then return to IDLE.
REQ-024 count SHALL hold its value until the next accepted start.
REQ-025 start while busy SHALL be ignored; the input operands SHALL not affect an operation in progress.
REQ-026 mask=8'hFF SHALL transfer all 8 registers with count = 8; count SHALL never wrap.

Reset
REQ-027 reset_n=0 SHALL asynchronously force IDLE, including mid-operation, with no further RAM write after assertion.
REQ-028 During reset: all outputs SHALL be 0 except ram_byte_enable=4'b1111; remaining mask and latched operands SHALL be cleared.
REQ-029 After reset_n deasserts, SHALL accept start on the first following edge.

Verification
REQ-030 Store, mask=8'b0000_0101, ascending, long, RAM r0=32'h1111_0000, r2=32'h2222_2222, out_ready=1 -> out_data 32'h1111_0000 then 32'h2222_2222; first out_valid 3 cycles after start; done; count=2.
REQ-031 Load, mask=8'b1000_0010, descending, word, in_valid=1, in_data=32'hAAAA_BEEF then 32'h5555_1234 -> writes r7 (BE 0011) then r1 in consecutive cycles; done 1 cycle later; count=2.
REQ-032 mask=0, start -> no ram_write_enable, no out_valid; done 2 cycles after the start edge; count=0.
REQ-033 Store with out_ready low for 5 cycles -> out_valid held high and out_data stable; exactly one word per handshake.
REQ-034 Load with mask=8'hFF, reset_n asserted after 3 writes -> outputs at reset values immediately; exactly 3 writes observed; next start accepted after release.
REQ-035 start pulsed while busy -> ignored; the original count completes; outputs unchanged from the single-operation run.
